// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the async FIFO write port among NREQ producers.
// One owner at a time streams up to MAX_BURST words, stalling on wr_full.
module fifo_wr_arbiter #(
  parameter int DSIZE     = 8,
  parameter int NREQ      = 4,
  parameter int MAX_BURST = 4
) (
  input  logic                  wr_clk,
  input  logic                  wr_rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*DSIZE-1:0] req_data,
  input  logic                  wr_full,
  output logic [NREQ-1:0]       grant,
  output logic [NREQ-1:0]       ack,
  output logic                  wr_inc,
  output logic [DSIZE-1:0]      wr_data,
  output logic                  busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(MAX_BURST + 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] BURST = 1'b1;

  logic [0:0]    state;
  logic [PW-1:0] owner;
  logic [PW-1:0] ptr;
  logic [CW-1:0] burst_cnt;

  logic [PW-1:0] sel;
  logic [PW-1:0] owner_next;
  logic          accept;
  logic          last_word;
  logic          release_grant;

  // First requester at or after ptr, wrapping; ptr may not be a power of two range.
  always_comb begin
    logic found;
    found = 1'b0;
    sel   = ptr;
    for (int k = 0; k < NREQ; k++) begin
      int ii;
      ii = (int'(ptr) + k) % NREQ;
      if (!found && req[ii]) begin
        found = 1'b1;
        sel   = PW'(ii);
      end
    end
  end

  always_comb begin
    owner_next    = (int'(owner) == NREQ - 1) ? '0 : owner + 1'b1;
    accept        = (state == BURST) && req[owner] && !wr_full;
    last_word     = accept && (burst_cnt == CW'(MAX_BURST - 1));
    release_grant = (state == BURST) && (!req[owner] || last_word);
  end

  always_comb begin
    busy    = (state == BURST);
    wr_inc  = accept;
    ack     = accept ? grant : '0;
    wr_data = (state == BURST) ? req_data[owner*DSIZE +: DSIZE] : '0;
  end

  // A dropped request or the final accepted word both return to IDLE,
  // leaving one bubble cycle before the next owner is chosen.
  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      state     <= IDLE;
      owner     <= '0;
      grant     <= '0;
      ptr       <= '0;
      burst_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            owner     <= sel;
            grant     <= NREQ'(1) << sel;
            burst_cnt <= '0;
            state     <= BURST;
          end
        end
        BURST: begin
          if (release_grant) begin
            state     <= IDLE;
            grant     <= '0;
            burst_cnt <= '0;
            ptr       <= owner_next;
          end else if (accept) begin
            burst_cnt <= burst_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          grant <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized bench for fifo_wr_arbiter against a cycle-level behavioural model
// of the arbitration rules (round-robin search, burst limit, back-pressure).
module tb_fifo_wr_arbiter;

  localparam int DSIZE     = 8;
  localparam int NREQ      = 4;
  localparam int MAX_BURST = 4;

  logic                  wr_clk = 1'b0;
  logic                  wr_rst = 1'b1;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*DSIZE-1:0] req_data = '0;
  logic                  wr_full = 1'b0;
  logic [NREQ-1:0]       grant;
  logic [NREQ-1:0]       ack;
  logic                  wr_inc;
  logic [DSIZE-1:0]      wr_data;
  logic                  busy;

  int compared = 0;
  int mismatched = 0;

  bit              mBusy = 1'b0;
  int              mOwner = 0;
  int              mCount = 0;
  int              mPtr = 0;
  int              seq[NREQ];
  logic [NREQ-1:0] reqV = '0;
  logic [NREQ-1:0] expAck = '0;
  logic            fullV = 1'b0;

  fifo_wr_arbiter #(.DSIZE(DSIZE), .NREQ(NREQ), .MAX_BURST(MAX_BURST)) dut (
    .wr_clk(wr_clk), .wr_rst(wr_rst), .req(req), .req_data(req_data),
    .wr_full(wr_full), .grant(grant), .ack(ack), .wr_inc(wr_inc),
    .wr_data(wr_data), .busy(busy)
  );

  always #5 wr_clk = ~wr_clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic logic [DSIZE-1:0] wordOf(input int i);
    return DSIZE'((i << 6) | (seq[i] & 63));
  endfunction

  task automatic applyStimulus();
    req     = reqV;
    wr_full = fullV;
    for (int i = 0; i < NREQ; i++) req_data[i*DSIZE +: DSIZE] = wordOf(i);
  endtask

  // One cycle: drive at the falling edge, compare, then advance the model past the rising edge.
  task automatic stepCycle(input string phase);
    logic [NREQ-1:0]  expGrant;
    logic [DSIZE-1:0] expData;
    bit               acc;
    bit               found;
    applyStimulus();
    #1;
    expGrant = mBusy ? NREQ'(1) << mOwner : '0;
    acc      = mBusy && reqV[mOwner] && !fullV;
    expAck   = acc ? expGrant : '0;
    expData  = mBusy ? wordOf(mOwner) : '0;
    checkOutput({phase, ".grant"},   32'(grant),   32'(expGrant));
    checkOutput({phase, ".ack"},     32'(ack),     32'(expAck));
    checkOutput({phase, ".wr_inc"},  32'(wr_inc),  32'(acc));
    checkOutput({phase, ".wr_data"}, 32'(wr_data), 32'(expData));
    checkOutput({phase, ".busy"},    32'(busy),    32'(mBusy));
    for (int i = 0; i < NREQ; i++) if (expAck[i]) seq[i]++;
    if (!mBusy) begin
      found = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
        int j;
        j = (mPtr + k) % NREQ;
        if (!found && reqV[j]) begin
          found  = 1'b1;
          mOwner = j;
        end
      end
      if (found) begin
        mBusy  = 1'b1;
        mCount = 0;
      end
    end else begin
      if (acc) mCount++;
      if (!reqV[mOwner] || mCount == MAX_BURST) begin
        mBusy  = 1'b0;
        mCount = 0;
        mPtr   = (mOwner + 1) % NREQ;
      end
    end
    @(negedge wr_clk);
  endtask

  // Requesters may only change req after their word was acknowledged (or while idle).
  task automatic updateReq(input logic [NREQ-1:0] mask, input int keepPct, input int raisePct);
    for (int i = 0; i < NREQ; i++) begin
      if (!mask[i]) reqV[i] = 1'b0;
      else if (expAck[i]) reqV[i] = ($urandom_range(99) < keepPct);
      else if (!reqV[i]) reqV[i] = ($urandom_range(99) < raisePct);
    end
  endtask

  task automatic resetModel();
    mBusy  = 1'b0;
    mCount = 0;
    mPtr   = 0;
    expAck = '0;
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) seq[i] = 0;
    applyStimulus();
    #2;
    checkOutput("reset.grant",   32'(grant),   32'd0);
    checkOutput("reset.ack",     32'(ack),     32'd0);
    checkOutput("reset.wr_inc",  32'(wr_inc),  32'd0);
    checkOutput("reset.wr_data", 32'(wr_data), 32'd0);
    checkOutput("reset.busy",    32'(busy),    32'd0);
    @(negedge wr_clk);
    wr_rst = 1'b0;

    reqV  = 4'b0001;
    fullV = 1'b0;
    for (int c = 0; c < 12; c++) begin
      stepCycle("single");
      updateReq(4'b0001, 100, 100);
    end

    reqV = '0;
    stepCycle("drain");
    stepCycle("drain");

    reqV = 4'b1111;
    for (int c = 0; c < 26; c++) stepCycle("rrobin");

    for (int c = 0; c < 400; c++) begin
      fullV = ($urandom_range(99) < 25);
      stepCycle("random");
      updateReq(4'b1111, 70, 40);
    end

    reqV  = 4'b1111;
    fullV = 1'b0;
    for (int c = 0; c < 4 && !mBusy; c++) stepCycle("prereset");
    stepCycle("prereset");
    applyStimulus();
    #2;
    wr_rst = 1'b1;
    #1;
    resetModel();
    checkOutput("midreset.grant",   32'(grant),   32'd0);
    checkOutput("midreset.wr_inc",  32'(wr_inc),  32'd0);
    checkOutput("midreset.wr_data", 32'(wr_data), 32'd0);
    checkOutput("midreset.busy",    32'(busy),    32'd0);
    @(negedge wr_clk);
    wr_rst = 1'b0;
    reqV   = 4'b1010;
    stepCycle("postreset");
    checkOutput("postreset.owner", 32'(mOwner), 32'd1);
    stepCycle("postreset");
    for (int c = 0; c < 150; c++) begin
      fullV = ($urandom_range(99) < 15);
      stepCycle("tail");
      updateReq(4'b1111, 60, 50);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
